// File: rtl/eth_metadata_queue.sv
// ============================================================================
// eth_metadata_queue: per-frame metadata capture plus a DEPTH-entry FWFT queue.
// Optional macro META_DROP_CNT_EN builds the saturating drop counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package eth_metadata_pkg;
  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  typedef struct packed {
    mac_addr_t  dest_mac;
    mac_addr_t  src_mac;
    logic       vlan_present;
    logic [11:0] vlan_id;
    ethertype_t resolved_ethertype;
    logic [4:0] l2_header_len;
    logic       is_ipv4;
    logic       is_ipv6;
    logic       is_arp;
    logic       is_unknown;
  } eth_metadata_t;
endpackage

module eth_metadata_queue
  import eth_metadata_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start_i,
  input  logic                         frame_end_i,
  input  logic                         frame_error_i,
  input  logic                         fields_valid_i,
  input  mac_addr_t                    dest_mac_i,
  input  mac_addr_t                    src_mac_i,
  input  logic                         vlan_valid_i,
  input  logic                         vlan_present_i,
  input  logic [11:0]                  vlan_id_i,
  input  ethertype_t                   resolved_ethertype_i,
  input  logic [4:0]                   l2_header_len_i,
  input  logic                         proto_valid_i,
  input  logic                         is_ipv4_i,
  input  logic                         is_ipv6_i,
  input  logic                         is_arp_i,
  input  logic                         is_unknown_i,
  output eth_metadata_t                m_metadata_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level_o,
  output logic                         overflow_o,
  output logic [CNT_W-1:0]             drop_count_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = $clog2(DEPTH + 1);
  localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_CAPTURED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  eth_metadata_t       stage_q, stage_d;
  eth_metadata_t       mem_q [DEPTH];
  logic [c_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [c_LVL_W-1:0]  count_q;
  logic                overflow_q;

  eth_metadata_t       w_cur_rec;
  eth_metadata_t       w_push_rec;
  logic                w_all_valid;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_wr_en;
  logic                w_drop;

  assign w_cur_rec = '{
    dest_mac:           dest_mac_i,
    src_mac:            src_mac_i,
    vlan_present:       vlan_present_i,
    vlan_id:            vlan_id_i,
    resolved_ethertype: resolved_ethertype_i,
    l2_header_len:      l2_header_len_i,
    is_ipv4:            is_ipv4_i,
    is_ipv6:            is_ipv6_i,
    is_arp:             is_arp_i,
    is_unknown:         is_unknown_i
  };

  assign w_all_valid = fields_valid_i && vlan_valid_i && proto_valid_i;

  // A closing frame (end or error) is resolved before a same-cycle frame_start opens the next one.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    w_push     = 1'b0;
    w_push_rec = stage_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start_i) state_d = S_COLLECT;
      end
      S_COLLECT, S_CAPTURED: begin
        if (frame_error_i) begin
          state_d = frame_start_i ? S_COLLECT : S_IDLE;
        end else if (frame_end_i) begin
          if (state_q == S_CAPTURED) begin
            w_push = 1'b1;
          end else if (w_all_valid) begin
            w_push     = 1'b1;
            w_push_rec = w_cur_rec;
          end
          state_d = frame_start_i ? S_COLLECT : S_IDLE;
        end else if (frame_start_i) begin
          state_d = S_COLLECT;
        end else if (state_q == S_COLLECT && w_all_valid) begin
          stage_d = w_cur_rec;
          state_d = S_CAPTURED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_valid_o    = (count_q != '0);
  assign w_pop        = m_valid_o && m_ready_i;
  assign w_full       = (count_q == c_FULL);
  assign w_wr_en      = w_push && (!w_full || w_pop);
  assign w_drop       = w_push && w_full && !w_pop;
  assign m_metadata_o = m_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fill_level_o = count_q;
  assign overflow_o   = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      overflow_q <= w_drop;
      if (w_wr_en) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop)   rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      case ({w_wr_en, w_pop})
        2'b10:   count_q <= count_q + c_LVL_W'(1);
        2'b01:   count_q <= count_q - c_LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q] <= w_push_rec;
  end

`ifdef META_DROP_CNT_EN
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (w_drop && (drop_q != '1)) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign drop_count_o = drop_q;
`else
  assign drop_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/eth_metadata_queue.md
# eth_metadata_queue

Parametrised successor to the single-entry metadata stage. Collects per-frame parser results (fields, VLAN resolution, protocol class) into one `eth_metadata_t` record, commits it only when the frame closes cleanly, and buffers up to `DEPTH` records. The buffered records go to downstream consumers over a valid/ready stream. Sits between the parser/classifier stages and the forwarding/lookup logic, and decouples frame timing from consumer backpressure.

## Interface
- `DEPTH`, 4, number of metadata entries; power of two, ≥2
- `CNT_W`, 16, width of the drop counter
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `frame_start`, `frame_end`, `frame_error`  in  1 each  frame delimiters; `frame_error` aborts the current frame
- `fields_valid`  in  1  `dest_mac`/`src_mac` valid
- `dest_mac`, `src_mac`  in  `mac_addr_t`  parsed addresses
- `vlan_valid`, `vlan_present`  in  1 each  VLAN resolution done / tag present
- `vlan_id`  in  12  VLAN ID
- `resolved_ethertype`  in  `ethertype_t`  post-VLAN ethertype
- `l2_header_len`  in  5  L2 header bytes
- `proto_valid`, `is_ipv4`, `is_ipv6`, `is_arp`, `is_unknown`  in  1 each  classification
- `m_metadata`  out  `eth_metadata_t`  head-of-queue record
- `m_valid`  out  1  head record valid
- `m_ready`  in  1  consumer accepts head
- `fill_level`  out  $clog2(DEPTH+1)  occupied entries
- `overflow`  out  1  one-cycle pulse when a completed record is dropped
- `drop_count`  out  `CNT_W`  saturating count of dropped records

## Operation
- Capture FSM with three states: IDLE, COLLECT, CAPTURED.
- IDLE → COLLECT on `frame_start`.
- In COLLECT, when `fields_valid && vlan_valid && proto_valid` are all high in the same cycle, latch every field into the staging record and go to CAPTURED. Later strobes in CAPTURED are ignored.
- CAPTURED + `frame_end`: push the staging record, go to IDLE.
- COLLECT + `frame_end` (record incomplete): discard silently, go to IDLE. No push, no count.
- COLLECT + all valids + `frame_end` in the same cycle: latch and push in that cycle, go to IDLE.
- `frame_error` in COLLECT or CAPTURED: discard, go to IDLE. `frame_error` takes priority over `frame_end`.
- `frame_start` in COLLECT or CAPTURED with no `frame_end`: discard the partial record and restart in COLLECT.
- `frame_end` and `frame_start` in the same cycle: close the current frame first, then enter COLLECT.
- In IDLE, `frame_end` and the valid strobes are ignored.
- Queue is a circular buffer with read/write pointers of width $clog2(DEPTH) that wrap modulo `DEPTH`, plus an occupancy counter.
- Push when full:
  - If a pop happens in the same cycle, the push succeeds.
  - Otherwise the record is dropped: `overflow` pulses for one cycle and `drop_count` increments, saturating at all-ones.
- Pop occurs when `m_valid && m_ready`. `m_ready` while empty has no effect.
- `m_metadata` follows first-word-fall-through and stays stable while `m_valid && !m_ready`.

## Timing
- Reset values: FSM IDLE, pointers 0, `fill_level` 0, `m_valid` 0, `m_metadata` '0, `overflow` 0, `drop_count` 0. Queue storage is not required to reset.
- Push-to-visible latency: `frame_end` sampled at edge N → `m_valid` = 1 and `m_metadata` = record after edge N (empty queue).
- Pop: head advances at the accepting edge. The next record, if any, is presented in the following cycle with no bubble.
- `fill_level` updates at the same edge as push/pop. A simultaneous push and pop leaves it unchanged.
- `rst` mid-frame or mid-transfer: queue flushed asynchronously, partial record lost, outputs return to reset values immediately.

## Configuration
- `META_DROP_CNT_EN` defined: `drop_count` is implemented as described.
- `META_DROP_CNT_EN` undefined: `drop_count` is tied to 0 and no counter logic is built. The `overflow` pulse and drop behaviour are unchanged.

## Test plan
- Single frame: `frame_start`, all valids with `dest_mac`=00:11:22:33:44:55 and `vlan_id`=0x064, then `frame_end`, `m_ready`=1 → `m_valid` for exactly 1 cycle, after the `frame_end` edge, with matching fields; `fill_level` goes 1→0.
- Backpressure/full: 5 complete frames with `DEPTH`=4 and `m_ready`=0 → `fill_level`=4, one `overflow` pulse, `drop_count`=1. Draining then yields the first 4 records in order.
- Full with simultaneous pop: queue full, push and `m_ready`=1 in the same cycle → no overflow, `fill_level` stays 4, new record appears last.
- Abort paths:
  - `frame_error` while CAPTURED → nothing pushed.
  - `frame_end` with `proto_valid` never asserted → nothing pushed, `drop_count` unchanged.
- Wrap and saturation: stream 3×`DEPTH` frames with random `m_ready` → order preserved across pointer wrap. With `CNT_W`=2, force 5 drops → `drop_count`=3. Without the macro → `drop_count`=0.
- Reset mid-frame with `fill_level`=2 → all outputs at reset values. The next clean frame is delivered correctly.
